// File: rtl/add_round_key_pipe_if.sv
// Handshake bus for the AddRoundKey pipeline stage.
// Carries the input state/round and the registered result back out.
interface add_round_key_pipe_if #(
  parameter int unsigned WORD_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*WORD_W-1:0]   in_state;
  logic [4:0]            in_round;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*WORD_W-1:0]   out_state;
  logic [4:0]            out_round;
  logic                  out_err;

  modport master (
    output in_valid, in_state, in_round, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_err
  );

  modport slave (
    input  in_valid, in_state, in_round, out_ready,
    output in_ready, out_valid, out_state, out_round, out_err
  );
endinterface

// File: rtl/add_round_key_pipe.sv
// Registered AddRoundKey stage with a local round-key store and range check.
// Optional key-store zeroize sweep enabled by defining ARK_KEY_ZEROIZE_EN.
module add_round_key_pipe #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned MAX_ROUNDS = 14,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [ADDR_W-1:0] key_wr_addr,
  input  logic [WORD_W-1:0] key_wr_data,
  input  logic [1:0]        key_size,
`ifdef ARK_KEY_ZEROIZE_EN
  input  logic              key_zeroize,
  output logic              zeroize_busy,
`endif
  add_round_key_pipe_if.slave bus
);
  localparam int unsigned DEPTH   = 4 * (MAX_ROUNDS + 1);
  localparam int unsigned STATE_W = 4 * WORD_W;
  localparam int unsigned IDX_W   = 7;

  logic [WORD_W-1:0]  keyMem [DEPTH];
  logic [3:0]         nrSel;
  logic               sizeBad;
  logic               roundErr;
  logic               accept;
  logic               wrInRange;
  logic               sweeping;
  logic [ADDR_W-1:0]  sweepIdx;
  logic [IDX_W-1:0]   baseIdx;
  logic [STATE_W-1:0] roundKey;

  logic               outValid;
  logic [STATE_W-1:0] outState;
  logic [4:0]         outRound;
  logic               outErr;

`ifdef ARK_KEY_ZEROIZE_EN
  typedef enum logic {Z_IDLE, Z_SWEEP} zState_t;
  zState_t zState;

  // Sweep clears one word per cycle from index 0; busy is high for DEPTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zState       <= Z_IDLE;
      sweepIdx     <= '0;
      zeroize_busy <= 1'b0;
    end else begin
      case (zState)
        Z_IDLE: begin
          if (key_zeroize) begin
            zState       <= Z_SWEEP;
            sweepIdx     <= '0;
            zeroize_busy <= 1'b1;
          end
        end
        Z_SWEEP: begin
          if (sweepIdx == ADDR_W'(DEPTH - 1)) begin
            zState       <= Z_IDLE;
            zeroize_busy <= 1'b0;
          end else begin
            sweepIdx <= sweepIdx + ADDR_W'(1);
          end
        end
        default: begin
          zState       <= Z_IDLE;
          zeroize_busy <= 1'b0;
        end
      endcase
    end
  end

  assign sweeping = (zState == Z_SWEEP);
`else
  assign sweeping = 1'b0;
  assign sweepIdx = '0;
`endif

  // Decode Nr from key_size; code 3 is reserved and always flags an error.
  always_comb begin
    nrSel   = 4'd10;
    sizeBad = 1'b0;
    case (key_size)
      2'd0:    nrSel = 4'd10;
      2'd1:    nrSel = 4'd12;
      2'd2:    nrSel = 4'd14;
      default: sizeBad = 1'b1;
    endcase
  end

  assign roundErr = sizeBad
                 || (bus.in_round > 5'(nrSel))
                 || (32'(nrSel) > MAX_ROUNDS);

  assign baseIdx = {bus.in_round, 2'b00};

  // Gather w[4r..4r+3]; an errored round XORs with zero so the state passes through.
  always_comb begin
    roundKey = '0;
    if (!roundErr) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (baseIdx + IDX_W'(c) == IDX_W'(i)) begin
            roundKey[STATE_W-1-c*WORD_W -: WORD_W] = keyMem[i];
          end
        end
      end
    end
  end

  assign wrInRange = ({1'b0, key_wr_addr} < (ADDR_W+1)'(DEPTH));

  // Key store: reads see the pre-edge value, so a same-cycle write lands for the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        keyMem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (sweeping) begin
          if (sweepIdx == ADDR_W'(i)) begin
            keyMem[i] <= '0;
          end
        end else if (key_wr_en && wrInRange && key_wr_addr == ADDR_W'(i)) begin
          keyMem[i] <= key_wr_data;
        end
      end
    end
  end

  assign bus.in_ready = !sweeping && (!outValid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Single output register slice; holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      outState <= '0;
      outRound <= '0;
      outErr   <= 1'b0;
    end else if (accept) begin
      outValid <= 1'b1;
      outState <= bus.in_state ^ roundKey;
      outRound <= bus.in_round;
      outErr   <= roundErr;
    end else if (bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_state = outState;
  assign bus.out_round = outRound;
  assign bus.out_err   = outErr;
endmodule

// File: tb/tb_add_round_key_pipe.sv
// Directed bench for add_round_key_pipe: vector table plus handshake,
// collision, async-reset and (optionally) zeroize sequences.
module tb_add_round_key_pipe;
  logic         clk;
  logic         reset;
  logic         key_wr_en;
  logic [5:0]   key_wr_addr;
  logic [31:0]  key_wr_data;
  logic [1:0]   key_size;
`ifdef ARK_KEY_ZEROIZE_EN
  logic         key_zeroize;
  logic         zeroize_busy;
`endif
  int total;
  int bad;

  add_round_key_pipe_if #(.WORD_W(32)) bus ();

  add_round_key_pipe #(.WORD_W(32), .MAX_ROUNDS(14), .ADDR_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .key_size    (key_size),
`ifdef ARK_KEY_ZEROIZE_EN
    .key_zeroize (key_zeroize),
    .zeroize_busy(zeroize_busy),
`endif
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  typedef struct {
    logic [1:0]   ks;
    logic [4:0]   rnd;
    logic [127:0] st;
    logic [127:0] expSt;
    logic         expErr;
  } vec_t;
  vec_t vecs[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wrKey(input logic [5:0] a, input logic [31:0] d);
    key_wr_en   = 1'b1;
    key_wr_addr = a;
    key_wr_data = d;
    cyc();
    key_wr_en   = 1'b0;
  endtask

  task automatic loadRound0();
    wrKey(6'd0, 32'h2b7e1516);
    wrKey(6'd1, 32'h28aed2a6);
    wrKey(6'd2, 32'habf71588);
    wrKey(6'd3, 32'h09cf4f3c);
  endtask

  task automatic sendOne(input logic [1:0] ks, input logic [4:0] r, input logic [127:0] s);
    key_size      = ks;
    bus.in_round  = r;
    bus.in_state  = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0; key_size = 2'd0;
`ifdef ARK_KEY_ZEROIZE_EN
    key_zeroize = 1'b0;
`endif
    bus.in_valid = 1'b0; bus.in_state = '0; bus.in_round = '0; bus.out_ready = 1'b1;

    vecs[0] = '{2'd0, 5'd0,  PT, CT0, 1'b0};
    vecs[1] = '{2'd0, 5'd11, {4{32'ha5a5a5a5}}, {4{32'ha5a5a5a5}}, 1'b1};
    vecs[2] = '{2'd2, 5'd14, 128'h00112233445566778899aabbccddeeff,
                128'h1100332266774455bbaa99888899aabb, 1'b0};
    vecs[3] = '{2'd3, 5'd0,  PT, PT, 1'b1};
    vecs[4] = '{2'd1, 5'd12, 128'h0123456789abcdeffedcba9876543210,
                128'hdf8efb8889abcdeffedcba9876543210, 1'b0};
    vecs[5] = '{2'd1, 5'd13, PT, PT, 1'b1};
    vecs[6] = '{2'd0, 5'd10, 128'hcafef00d, 128'hcafef00d, 1'b0};
    vecs[7] = '{2'd2, 5'd15, K0, K0, 1'b1};

    // Reset values
    #23;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_state", bus.out_state, 128'd0);
    chk("rst_out_round", 128'(bus.out_round), 128'd0);
    chk("rst_out_err",   128'(bus.out_err), 128'd0);
    reset = 1'b0;
    cyc();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

    // Key load: round 0, w[48], w[56..59], and an out-of-store write
    loadRound0();
    wrKey(6'd48, 32'hdeadbeef);
    wrKey(6'd56, 32'h11111111);
    wrKey(6'd57, 32'h22222222);
    wrKey(6'd58, 32'h33333333);
    wrKey(6'd59, 32'h44444444);
    wrKey(6'd63, 32'hffffffff);

    // Table-driven vectors, one per cycle
    for (int i = 0; i < 8; i++) begin
      sendOne(vecs[i].ks, vecs[i].rnd, vecs[i].st);
      chk($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'd1);
      chk($sformatf("vec%0d_state", i), bus.out_state, vecs[i].expSt);
      chk($sformatf("vec%0d_round", i), 128'(bus.out_round), 128'(vecs[i].rnd));
      chk($sformatf("vec%0d_err", i),   128'(bus.out_err), 128'(vecs[i].expErr));
    end
    cyc();
    chk("drain_valid", 128'(bus.out_valid), 128'd0);

    // Back-pressure: hold result for 5 cycles, key_size changed meanwhile
    sendOne(2'd0, 5'd0, PT);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_state  = 128'd0;
    key_size      = 2'd3;
    #1;
    chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_hold%0d_state", i), bus.out_state, CT0);
      chk($sformatf("bp_hold%0d_err", i), 128'(bus.out_err), 128'd0);
      chk($sformatf("bp_hold%0d_ready", i), 128'(bus.in_ready), 128'd0);
    end
    key_size      = 2'd0;
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_r0_valid", 128'(bus.out_valid), 128'd1);
    chk("bp_r0_state", bus.out_state, K0);
    bus.in_state = {128{1'b1}};
    cyc();
    chk("bp_r1_state", bus.out_state, 128'hd481eae9d7512d595408ea77f630b0c3);
    bus.in_state = PT;
    cyc();
    chk("bp_r2_state", bus.out_state, CT0);
    bus.in_valid = 1'b0;
    cyc();
    chk("bp_end_valid", 128'(bus.out_valid), 128'd0);

    // Same-edge key write and read of w[4]
    key_wr_en = 1'b1; key_wr_addr = 6'd4; key_wr_data = 32'hffffffff;
    sendOne(2'd0, 5'd1, PT);
    key_wr_en = 1'b0;
    chk("coll_old_state", bus.out_state, PT);
    sendOne(2'd0, 5'd1, PT);
    chk("coll_new_state", bus.out_state, 128'hcdbc0957885a308d313198a2e0370734);
    chk("coll_new_err", 128'(bus.out_err), 128'd0);

    // Async reset mid-cycle with a pending result
    bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 128'(bus.out_valid), 128'd0);
    chk("areset_state", bus.out_state, 128'd0);
    #2 reset = 1'b0;
    cyc();
    sendOne(2'd0, 5'd0, PT);
    chk("post_reset_state", bus.out_state, PT);
    chk("post_reset_err", 128'(bus.out_err), 128'd0);

`ifdef ARK_KEY_ZEROIZE_EN
    begin
      int cnt;
      loadRound0();
      sendOne(2'd0, 5'd0, PT);
      chk("z_pre_state", bus.out_state, CT0);
      key_zeroize = 1'b1;
      cyc();
      key_zeroize = 1'b0;
      key_wr_en = 1'b1; key_wr_addr = 6'd0; key_wr_data = 32'h12345678;
      cnt = 0;
      while (zeroize_busy && cnt < 200) begin
        chk("z_in_ready", 128'(bus.in_ready), 128'd0);
        cnt++;
        cyc();
      end
      key_wr_en = 1'b0;
      chk("z_busy_cycles", 128'(cnt), 128'd60);
      sendOne(2'd0, 5'd0, PT);
      chk("z_post_state", bus.out_state, PT);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_round_key_pipe.md
Name: add_round_key_pipe

Overview:
- Registered, handshaked AddRoundKey stage with an internal round-key store.
- Successor to the combinational round-key XOR:
  - round keys are loaded word-by-word into a local register file rather than taken from a flat expanded-key bus;
  - supports AES-128/192/256 round counts;
  - out-of-range rounds are flagged.
- Sits between the MixColumns/ShiftRows stages and the round controller in the cipher datapath.

Parameters:
- WORD_W, 32, width of one key-schedule word (one state column).
- MAX_ROUNDS, 14, largest Nr supported; key store depth = 4*(MAX_ROUNDS+1) words.
- ADDR_W, 6, key write address width; must satisfy 2**ADDR_W >= 4*(MAX_ROUNDS+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_wr_en  in  1  write one key word this cycle.
- key_wr_addr  in  ADDR_W  word index w[i]; index 0 = first word of round 0.
- key_wr_data  in  WORD_W  key word.
- key_size  in  2  0:Nr=10, 1:Nr=12, 2:Nr=14, 3:reserved.
- in_valid  in  1  input state valid.
- in_ready  out  1  stage can accept.
- in_state  in  4*WORD_W  state; column 0 = [4*WORD_W-1 -: WORD_W], column 3 = [WORD_W-1:0].
- in_round  in  5  round index r.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_state  out  4*WORD_W  in_state XOR {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- out_round  out  5  round index carried with the result.
- out_err  out  1  round out of range for key_size, or key_size==3.

Behaviour:
- Reset (async, active-high): out_valid=0, out_state=0, out_round=0, out_err=0.
  - Key store is cleared to all zero.
  - in_ready=1 after reset deasserts.
- Key store:
  - 4*(MAX_ROUNDS+1) registers of WORD_W bits.
  - Write occurs on a clk edge when key_wr_en=1 and key_wr_addr < 4*(MAX_ROUNDS+1).
  - Writes to addresses beyond the store are ignored.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. On accept, out_state/out_round/out_err load on the same edge, and out_valid=1 next cycle. Latency is 1 cycle.
  - When out_ready=1 and there is no accept, out_valid clears.
  - When out_valid=1 and out_ready=0, all outputs hold stable.
- Full throughput: one accept per cycle while out_ready=1.
- Range check: Nr decoded from key_size at accept time.
  - If in_round > Nr, or key_size==3: out_err=1, and out_state = in_state unmodified (XOR with zero).
  - Otherwise out_err=0.
- Simultaneous key write and accept reading the same word: the XOR uses the OLD word; the new value is visible from the next accept.
- Changing key_size while out_valid=1 does not alter the held result.
- Reset mid-transfer: the pending result is dropped, out_valid=0 immediately (asynchronous).

Optional Feature:
- Macro: ARK_KEY_ZEROIZE_EN.
- Defined:
  - Adds input key_zeroize (1 bit) and output zeroize_busy (1 bit).
  - A key_zeroize pulse while idle starts a sweep that clears one key word per cycle, from index 0 upward. The sweep takes 4*(MAX_ROUNDS+1) cycles; zeroize_busy=1 throughout.
  - During the sweep:
    - in_ready=0;
    - key_wr_en is ignored;
    - an already-valid output still drains normally.
  - key_zeroize while busy is ignored.
  - Reset aborts the sweep: zeroize_busy=0, and the store is cleared by reset.
- Undefined: neither port exists; the key store is cleared only by reset.

Test Plan:
- Vector check: load round-0 words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c. Then in_state=3243f6a8885a308d313198a2e0370734, in_round=0, key_size=0 -> one cycle later out_valid=1, out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_err=0.
- Back-pressure: hold out_ready=0 with in_valid=1 -> in_ready=0, and out_state stays constant for 5 cycles. Then out_ready=1 for 3 cycles with 3 inputs -> 3 results in order, one per cycle.
- Range: key_size=0, in_round=11 -> out_err=1 and out_state==in_state. key_size=2, in_round=14 -> out_err=0, XOR with w[56..59].
- Write/read collision: accept round 1 while writing w[4]=ffffffff (old value 0) -> column 0 unchanged. The next accept of round 1 has column 0 inverted.
- Async reset asserted mid-cycle while out_valid=1 -> out_valid=0 before the next clk edge; a subsequent round-0 XOR uses zero key (output equals input).
- With ARK_KEY_ZEROIZE_EN: zeroize after load -> zeroize_busy=1 for 60 cycles and in_ready=0. Afterwards the round-0 vector returns 3243f6a8885a308d313198a2e0370734.
